// File: rtl/axis_insert_header_sched_if.sv
// Header (insert) and payload stream channels toward an insert-header engine.
// N lanes are packed side by side; lane i occupies slice i of every bus.
interface axis_insert_header_sched_if #(
    parameter int unsigned DATA_WD = 32,
    parameter int unsigned N       = 1
) ();
    localparam int unsigned DATA_BYTE_WD = DATA_WD / 8;
    localparam int unsigned BYTE_CNT_WD  = $clog2(DATA_BYTE_WD);

    logic [N-1:0]              valid_insert;
    logic [N*DATA_WD-1:0]      data_insert;
    logic [N*DATA_BYTE_WD-1:0] keep_insert;
    logic [N*BYTE_CNT_WD-1:0]  byte_insert_cnt;
    logic [N-1:0]              ready_insert;

    logic [N-1:0]              valid_in;
    logic [N*DATA_WD-1:0]      data_in;
    logic [N*DATA_BYTE_WD-1:0] keep_in;
    logic [N-1:0]              last_in;
    logic [N-1:0]              ready_in;

    modport master (
        output valid_insert, data_insert, keep_insert, byte_insert_cnt,
        input  ready_insert,
        output valid_in, data_in, keep_in, last_in,
        input  ready_in
    );

    modport slave (
        input  valid_insert, data_insert, keep_insert, byte_insert_cnt,
        output ready_insert,
        input  valid_in, data_in, keep_in, last_in,
        output ready_in
    );
endinterface

// File: rtl/axis_insert_header_sched.sv
// Packet-level round-robin scheduler sharing one insert-header engine among N_SRC sources.
// A grant covers one header followed by one payload packet; it is released on the last beat.
module axis_insert_header_sched #(
    parameter int unsigned DATA_WD      = 32,
    parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
    parameter int unsigned BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
    parameter int unsigned N_SRC        = 4,
    parameter int unsigned SRC_WD       = $clog2(N_SRC)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_SRC-1:0]          src_en_i,
    axis_insert_header_sched_if.slave  src_if,
    axis_insert_header_sched_if.master eng_if,
    output logic                      grant_valid_o,
    output logic [SRC_WD-1:0]         grant_id_o,
    output logic                      pkt_done_o,
    output logic [15:0]               pkt_cnt_o
);

    typedef enum logic [1:0] {StIdle, StHdr, StBody} state_e;

    state_e            state_q, state_d;
    logic [SRC_WD-1:0] grant_q, grant_d;
    logic [SRC_WD-1:0] rr_q, rr_d;
    logic              done_q, done_d;
    logic [15:0]       cnt_q, cnt_d;

    logic [N_SRC-1:0]   req;
    logic [2*N_SRC-1:0] req_rot;
    logic [SRC_WD:0]    pick_sum;
    logic [SRC_WD-1:0]  pick;
    int unsigned        pick_off;

    // Rotate the request vector so bit 0 is rr_q; the lowest set bit is the winner.
    always_comb begin
        req      = src_if.valid_insert & src_en_i;
        req_rot  = {req, req} >> rr_q;
        pick_off = 0;
        for (int j = N_SRC - 1; j >= 0; j--) begin
            if (req_rot[j]) pick_off = j;
        end
        pick_sum = {1'b0, rr_q} + (SRC_WD + 1)'(pick_off);
        if (pick_sum >= (SRC_WD + 1)'(N_SRC)) pick_sum = pick_sum - (SRC_WD + 1)'(N_SRC);
        pick = pick_sum[SRC_WD-1:0];
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;

        eng_if.valid_insert    = '0;
        eng_if.data_insert     = '0;
        eng_if.keep_insert     = '0;
        eng_if.byte_insert_cnt = '0;
        eng_if.valid_in        = '0;
        eng_if.data_in         = '0;
        eng_if.keep_in         = '0;
        eng_if.last_in         = '0;
        src_if.ready_insert    = '0;
        src_if.ready_in        = '0;

        // Ready depends only on registered state and the engine, never on source valid.
        for (int i = 0; i < N_SRC; i++) begin
            if (grant_q == SRC_WD'(i)) begin
                if (state_q == StHdr) begin
                    eng_if.valid_insert    = src_if.valid_insert[i];
                    eng_if.data_insert     = src_if.data_insert[i*DATA_WD +: DATA_WD];
                    eng_if.keep_insert     = src_if.keep_insert[i*DATA_BYTE_WD +: DATA_BYTE_WD];
                    eng_if.byte_insert_cnt =
                        src_if.byte_insert_cnt[i*BYTE_CNT_WD +: BYTE_CNT_WD];
                    src_if.ready_insert[i] = eng_if.ready_insert[0];
                end
                if (state_q == StBody) begin
                    eng_if.valid_in    = src_if.valid_in[i];
                    eng_if.data_in     = src_if.data_in[i*DATA_WD +: DATA_WD];
                    eng_if.keep_in     = src_if.keep_in[i*DATA_BYTE_WD +: DATA_BYTE_WD];
                    eng_if.last_in     = src_if.last_in[i];
                    src_if.ready_in[i] = eng_if.ready_in[0];
                end
            end
        end

        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    grant_d = pick;
                    state_d = StHdr;
                end
            end
            StHdr: begin
                if (eng_if.valid_insert[0] && eng_if.ready_insert[0]) state_d = StBody;
            end
            StBody: begin
                if (eng_if.valid_in[0] && eng_if.ready_in[0] && eng_if.last_in[0]) begin
                    state_d = StIdle;
                    rr_d    = (grant_q == SRC_WD'(N_SRC - 1)) ? '0 : grant_q + SRC_WD'(1);
                    done_d  = 1'b1;
                    if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            grant_q <= '0;
            rr_q    <= '0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    assign grant_valid_o = (state_q != StIdle);
    assign grant_id_o    = grant_q;
    assign pkt_done_o    = done_q;
    assign pkt_cnt_o     = cnt_q;

endmodule
